// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory between fetch and data ports,
// data-first with a starvation counter that guarantees fetch progress.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, RESP} state_t;
    state_t r_state, w_next;
    logic [SW-1:0] r_starve_cnt, w_starve_cnt;
    logic w_idle, w_wait, w_hold, w_grant_i, w_grant_d;
    logic w_mem_req, w_mem_we, w_i_ack, w_d_ack;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata, w_i_rdata, w_d_rdata;

    assign w_idle = r_state == IDLE;
    assign w_wait = r_state == I_WAIT || r_state == D_WAIT;
    assign w_hold = w_wait && !mem_ready;
    assign busy   = !w_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // fetch wins only when alone or once data has been granted STARVE_MAX times in a row
    always_comb begin
        w_grant_i = w_idle && i_req && (!d_req || r_starve_cnt == SW'(STARVE_MAX));
        w_grant_d = w_idle && d_req && !w_grant_i;
        w_next    = w_idle ? (w_grant_i ? I_WAIT : w_grant_d ? D_WAIT : IDLE) :
                    r_state == RESP ? IDLE :
                    mem_ready ? RESP : r_state;
    end

    always_comb begin
        w_mem_req    = w_grant_i || w_grant_d || w_hold;
        w_mem_we     = w_grant_d ? d_we : w_hold && mem_we;
        w_mem_addr   = w_grant_i ? i_addr : w_grant_d ? d_addr : mem_addr;
        w_mem_wdata  = w_grant_d ? d_wdata : mem_wdata;
        w_i_ack      = r_state == I_WAIT && mem_ready;
        w_d_ack      = r_state == D_WAIT && mem_ready;
        w_i_rdata    = w_i_ack ? mem_rdata : i_rdata;
        w_d_rdata    = (w_d_ack && !mem_we) ? mem_rdata : d_rdata;
        w_starve_cnt = w_grant_i ? '0 :
                       (w_grant_d && i_req && r_starve_cnt != SW'(STARVE_MAX)) ?
                       r_starve_cnt + SW'(1) : r_starve_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            r_starve_cnt <= '0;
        end else begin
            mem_req      <= w_mem_req;
            mem_we       <= w_mem_we;
            mem_addr     <= w_mem_addr;
            mem_wdata    <= w_mem_wdata;
            i_ack        <= w_i_ack;
            d_ack        <= w_d_ack;
            i_rdata      <= w_i_rdata;
            d_rdata      <= w_d_rdata;
            r_starve_cnt <= w_starve_cnt;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, handshake timing, starvation and reset.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ack, d_ack, mem_req, mem_we, busy;
    int          n_chk = 0, n_fail = 0;
    int          n;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // waits for a grant, checks its address, answers after `waits` wait cycles, checks the ack
    task automatic xact(input string tag, input logic is_i, input logic [31:0] addr,
                        input logic [31:0] rd, input int waits, output int cyc);
        cyc = 0;
        @(negedge clk);
        while (!mem_req && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_req"}, mem_req, 1);
        check({tag, "_addr"}, mem_addr, addr);
        repeat (waits) @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ready = 1'b0;
        check({tag, "_iack"}, i_ack, is_i);
        check({tag, "_dack"}, d_ack, !is_i);
        check({tag, "_reqoff"}, mem_req, 0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {i_ack, d_ack, mem_we}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        rst = 1'b0;

        // fetch only, zero-wait memory
        i_req = 1'b1; i_addr = 32'h40; mem_rdata = 32'h13;
        @(negedge clk);
        check("f_req", mem_req, 1);
        check("f_addr", mem_addr, 32'h40);
        check("f_we", mem_we, 0);
        check("f_busy", busy, 1);
        check("f_ack_early", i_ack, 0);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0; i_req = 1'b0;
        check("f_ack", i_ack, 1);
        check("f_rdata", i_rdata, 32'h13);
        check("f_dack", d_ack, 0);
        check("f_reqoff", mem_req, 0);
        @(negedge clk);
        check("f_ackoff", i_ack, 0);
        check("f_idle", busy, 0);
        check("f_drdata", d_rdata, 0);

        // data write with 3 wait cycles
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFEBABE;
        mem_rdata = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("w_req", mem_req, 1);
            check("w_cmd", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h100, 32'hCAFEBABE});
            check("w_noack", d_ack, 0);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;
        check("w_ack", d_ack, 1);
        check("w_rdata", d_rdata, 0);
        check("w_weoff", {mem_req, mem_we}, 0);
        @(negedge clk);
        check("w_ackonce", d_ack, 0);

        // contention: four data grants, then fetch
        i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            xact("cd", 1'b0, 32'h300 + 32'(4 * k), 32'h1000 + 32'(k), 0, n);
            d_addr = 32'h304 + 32'(4 * k);
        end
        check("starve_full", dut.r_starve_cnt, 4);
        xact("ci", 1'b1, 32'h200, 32'h5555AAAA, 0, n);
        check("ci_rdata", i_rdata, 32'h5555AAAA);
        check("starve_clr", dut.r_starve_cnt, 0);
        i_req = 1'b0;
        xact("cd4", 1'b0, 32'h310, 32'h1004, 0, n);
        check("cd4_rdata", d_rdata, 32'h1004);
        d_req = 1'b0;

        // back-to-back reads
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h10;
        xact("b0", 1'b0, 32'h10, 32'h11111111, 0, n);
        check("b0_rdata", d_rdata, 32'h11111111);
        d_addr = 32'h14;
        xact("b1", 1'b0, 32'h14, 32'h22222222, 0, n);
        check("b_interval", n, 1);
        check("b1_rdata", d_rdata, 32'h22222222);
        d_req = 1'b0;

        // async reset in D_WAIT
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h400;
        @(negedge clk);
        check("r_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("r_async", {mem_req, busy, i_ack, d_ack}, 0);
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("r_noack", {i_ack, d_ack, busy}, 0);
        i_req = 1'b1; i_addr = 32'h44;
        xact("ri", 1'b1, 32'h44, 32'h0000ABCD, 1, n);
        check("ri_rdata", i_rdata, 32'h0000ABCD);
        i_req = 1'b0;

        // spurious mem_ready while idle
        @(negedge clk);
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("sp_idle", {busy, mem_req, i_ack, d_ack}, 0);
        end
        mem_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port and data port. The block arbitrates between the two requests and latches the winner's command. It then drives a req/ready handshake to memory and returns read data with a one-cycle ack pulse. The pipeline stalls fetch or memory stages while their ack is outstanding. Data accesses normally win, but a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants, while i_req is pending, after which fetch gets priority (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request; held with i_addr stable until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid while i_ack=1, held afterwards
- i_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ack=1 for reads, held afterwards
- d_ack  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory command valid
- mem_we  out  1  memory write enable (qualified by mem_req)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory completes the current command this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, I_WAIT, D_WAIT, RESP. The state register and all outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Only one requester active: grant it.
  - Both requesters active: grant D unless starve_cnt == STARVE_MAX, in which case grant I.
  - On grant: latch mem_addr (and for D, mem_we=d_we and mem_wdata=d_wdata), set mem_req=1, go to I_WAIT or D_WAIT.
- I_WAIT / D_WAIT:
  - Hold mem_req=1 and the latched command stable.
  - mem_ready=0: stay.
  - mem_ready=1: at the edge, clear mem_req and mem_we, pulse the matching ack, go to RESP.
  - An I completion loads i_rdata←mem_rdata. A D read completion loads d_rdata←mem_rdata. A D write leaves d_rdata unchanged.
- RESP: one cycle with the ack high. Requests are not sampled in this cycle. Next state is IDLE, and the ack clears.
- starve_cnt, width $clog2(STARVE_MAX+1):
  - Increments (saturating at STARVE_MAX) on a D grant while i_req=1.
  - Clears to 0 on any I grant.
  - Otherwise holds.
- mem_addr and mem_wdata hold their last latched value when idle. Memory must ignore them when mem_req=0.
- A request dropped before its ack is a protocol violation; behaviour is unspecified. The latched command always completes.
- mem_ready while mem_req=0 is ignored.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, busy=0, starve_cnt=0.
- Reset asserted mid-transaction aborts it immediately, with no ack. Memory must tolerate mem_req dropping without mem_ready.
- Request sampled in IDLE at edge E: mem_req=1 from E.
- mem_ready=1 sampled at edge E+L (L≥1 wait cycles): ack=1 from E+L for exactly one cycle.
- Next IDLE begins at E+L+1. The earliest next grant is edge E+L+2.
- Minimum request-to-ack latency is 2 cycles (req seen in IDLE, mem_ready in the first WAIT cycle). Minimum issue interval is 3 cycles.
- Simultaneous i_req and d_req in IDLE are resolved by the priority rule above. The loser keeps waiting; no request is lost.
- busy=1 exactly in I_WAIT, D_WAIT and RESP.

## Test plan
- Reset then fetch only: i_req=1, i_addr=0x40; memory returns 0x00000013 with mem_ready on the first WAIT cycle. Expect mem_addr=0x40 and mem_we=0, i_ack pulse 2 cycles after i_req with i_rdata=0x13. Then d_ack=0 and d_rdata=0.
- Data write with 3 wait cycles: d_we=1, d_addr=0x100, d_wdata=0xCAFEBABE. Expect mem_req held 4 cycles with a stable command and mem_we=1. Expect d_ack exactly once, d_rdata unchanged, and mem_we=0 after completion.
- Contention and starvation with STARVE_MAX=4: i_req and d_req held continuously, each D ack followed by a new D read. Expect grant order D,D,D,D,I, and starve_cnt back to 0 after the I grant.
- Back-to-back reads: two D reads from 0x10 and 0x14 returning 0x11111111 and 0x22222222. Expect d_rdata values in order, issue interval exactly 3 cycles with zero-wait memory, and never two acks in one cycle.
- Async reset during D_WAIT: assert rst between clock edges. Expect mem_req, busy and acks low immediately, no ack for the aborted access, and a fresh i_req after reset served normally.
- Spurious mem_ready=1 in IDLE with no requests: no state change and no ack.
